aesl_deadlock_stall_detector: RTL

AESL_DEADLOCK_STALL_DETECTOR -- requirements
Module: aesl_deadlock_stall_detector

---
 rtl/aesl_deadlock_stall_detector.sv | 114 +++++++++++
 1 files changed

// File: rtl/aesl_deadlock_stall_detector.sv
`default_nettype none
// ============================================================================
// Module   : aesl_deadlock_stall_detector
// Brief    : Flags a kernel deadlock when the same stalled flag vector
//            persists for THRESHOLD consecutive samples after a holdoff.
// Revision : 1.0 - initial release
// ============================================================================
module aesl_deadlock_stall_detector #(
   parameter int N_AXIS    = 2,
   parameter int N_INST    = 2,
   parameter int N_BLK     = 1,
   parameter int HOLDOFF   = 10,
   parameter int THRESHOLD = 16
) (
   input  logic                    kernel_monitor_clock,
   input  logic                    kernel_monitor_reset,
   input  logic [N_AXIS-1:0]       axis_block_sigs,
   input  logic [N_INST-1:0]       inst_idle_sigs,
   input  logic [N_BLK-1:0]        inst_block_sigs,
   output logic                    block,
   output logic                    block_pulse,
   output logic [N_AXIS-1:0]       axis_snap,
   output logic [N_INST+N_BLK-1:0] inst_snap,
   output logic [15:0]             blocked_cycles
);

   localparam int VW = N_INST + N_BLK + N_AXIS;
   localparam int CW = $clog2(THRESHOLD + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(THRESHOLD - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [7:0]    HOLD_LAST = 8'(HOLDOFF - 1);

   typedef enum logic [1:0] {
      ST_HOLDOFF = 2'd0,
      ST_MONITOR = 2'd1,
      ST_ARMED   = 2'd2,
      ST_BLOCKED = 2'd3
   } state_t;

   state_t          r_state;
   logic [7:0]      r_hold_cnt;
   logic [CW-1:0]   r_cnt;
   logic [VW-1:0]   r_cap;

   logic            w_stall;
   logic [VW-1:0]   w_vec;

   // Idle flags never stall by themselves; they only break vector equality.
   assign w_stall = (|axis_block_sigs) | (|inst_block_sigs);
   assign w_vec   = {inst_idle_sigs, inst_block_sigs, axis_block_sigs};

   always_ff @(posedge kernel_monitor_clock) begin
      if (kernel_monitor_reset) begin
         r_state        <= ST_HOLDOFF;
         r_hold_cnt     <= '0;
         r_cnt          <= '0;
         r_cap          <= '0;
         block          <= 1'b0;
         block_pulse    <= 1'b0;
         axis_snap      <= '0;
         inst_snap      <= '0;
         blocked_cycles <= '0;
      end else begin
         block_pulse <= 1'b0;
         case (r_state)
            ST_HOLDOFF: begin
               if (r_hold_cnt == HOLD_LAST) begin
                  r_state <= ST_MONITOR;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 8'd1;
               end
            end
            ST_MONITOR: begin
               if (w_stall) begin
                  r_state <= ST_ARMED;
                  r_cap   <= w_vec;
                  r_cnt   <= CNT_ONE;
               end else begin
                  r_cnt   <= '0;
               end
            end
            ST_ARMED: begin
               if (!w_stall) begin
                  r_state <= ST_MONITOR;
                  r_cnt   <= '0;
               end else if (w_vec != r_cap) begin
                  // Any change in the flag vector is progress: restart the run.
                  r_cap   <= w_vec;
                  r_cnt   <= CNT_ONE;
               end else if (r_cnt == CNT_LAST) begin
                  r_state        <= ST_BLOCKED;
                  block          <= 1'b1;
                  block_pulse    <= 1'b1;
                  axis_snap      <= axis_block_sigs;
                  inst_snap      <= {inst_idle_sigs, inst_block_sigs};
                  blocked_cycles <= 16'd1;
               end else begin
                  r_cnt   <= r_cnt + CNT_ONE;
               end
            end
            ST_BLOCKED: begin
               if (blocked_cycles != 16'hFFFF) begin
                  blocked_cycles <= blocked_cycles + 16'd1;
               end
            end
            default: begin
               r_state <= ST_HOLDOFF;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
